multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I core, for the variant where the instruction/data memory port is shared. It steps one instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles. Each cycle it drives the datapath mux selects, write enables and ALUControl. It waits on a memory-ready handshake, and supports lw, sw, R-type, I-type ALU, beq/bne and jal.

---
 rtl/multicycle_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer for a core with a shared instruction/data
// memory port. Walks one instruction through fetch, decode, execute, memory and
// writeback, driving datapath selects, write enables and ALUControl each cycle.
module multicycle_ctrl_fsm #(
  parameter int ALUCTL_W = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          Op,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                instr_done,
  output logic                illegal,
  output logic [STATE_W-1:0]  dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(4'b0000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(4'b0001);
  localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(4'b0010);
  localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(4'b0011);
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(4'b0100);
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(4'b0101);
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = ALUCTL_W'(4'b0110);
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = ALUCTL_W'(4'b0111);
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = ALUCTL_W'(4'b1000);
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(4'b1001);

  state_t              state;
  state_t              state_next;
  logic                retire;
  logic [ALUCTL_W-1:0] alu_op;
  logic                is_rtype;
  logic                unused_funct7_bits;

  assign is_rtype           = (Op == OP_RTYPE);
  assign dbg_state          = state;
  assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

  // ALU operation decode from funct3/funct7 for R-type and I-type ALU ops
  always_comb begin
    alu_op = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_op = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = ALU_ADD;
    retire     = 1'b0;

    unique case (state)
      S_FETCH: begin
        // PC+4 goes straight back to the PC through the ALU result path
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end

      S_DECODE: begin
        // OldPC + imm lands in ALUOut so a taken branch can use it later
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (Op)
          OP_LOAD: begin
            ImmSrc     = 2'b00;
            state_next = S_MEMADR;
          end
          OP_STORE: begin
            ImmSrc     = 2'b01;
            state_next = S_MEMADR;
          end
          OP_RTYPE:  state_next = S_EXECR;
          OP_ITYPE:  state_next = S_EXECI;
          OP_BRANCH: begin
            ImmSrc     = 2'b10;
            state_next = S_BRANCH;
          end
          OP_JAL: begin
            ImmSrc     = 2'b11;
            state_next = S_JAL;
          end
          default:   state_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (Op == OP_STORE) begin
          ImmSrc     = 2'b01;
          state_next = S_MEMWRITE;
        end else begin
          ImmSrc     = 2'b00;
          state_next = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWRITE: begin
        // Strobe held until the shared port accepts the write
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_op;
        state_next = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b00;
        ALUControl = alu_op;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        // rs1-rs2 sets Zero; bne is beq with the sense flipped by funct3[0]
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        ResultSrc  = 2'b00;
        if (funct3[2:1] == 2'b00) begin
          PCWrite    = Zero ^ funct3[0];
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_TRAP;
        end
      end

      S_JAL: begin
        // Jump target already in ALUOut; compute OldPC+4 for the link write
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b00;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_FETCH;
    endcase
  end

  // State register, retire pulse and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_next;
      instr_done <= retire;
      illegal    <= illegal | (state_next == S_TRAP);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a per-cycle vector table for normal
// instruction flows plus hand-written sequences for trap and reset corners.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] F7A = 7'b0100000;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3;
  localparam logic [3:0] S_MW = 4'd4, S_MWR = 4'd5, S_XR = 4'd6, S_XI = 4'd7;
  localparam logic [3:0] S_AW = 4'd8, S_BR = 4'd9, S_J = 4'd10, S_T = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  logic       instr_done, illegal;
  logic [3:0] dbg_state;
  logic [22:0] act;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl_fsm #(.ALUCTL_W(4), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign act = {dbg_state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [22:0] ex(input logic [3:0] st, input logic pcw,
      input logic adr, input logic irw, input logic mw, input logic rw,
      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
      input logic [1:0] imm, input logic [3:0] alu, input logic done,
      input logic ill);
    return {st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, done, ill};
  endfunction

  function automatic logic [22:0] e_fetch(input logic rdy, input logic done);
    return ex(S_F, rdy, 1'b0, rdy, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, done, 1'b0);
  endfunction

  function automatic logic [22:0] e_dec(input logic [1:0] imm);
    return ex(S_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'h0, 1'b0, 1'b0);
  endfunction

  function automatic logic [22:0] e_wb();
    return ex(S_AW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
  endfunction

  task automatic add(input string n, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic z, input logic rdy, input logic [22:0] e);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic z, input logic rdy);
    Op = op; funct3 = f3; funct7 = f7; Zero = z; mem_ready = rdy;
  endtask

  task automatic chk(input string n, input logic [22:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (state|pcw adr irw mw rw|rs sa sb imm|alu|done ill)",
               n, act, e);
    end
  endtask

  task automatic chk_sdi(input string n, input logic [3:0] st, input logic done, input logic ill);
    n_cmp++;
    if ({dbg_state, instr_done, illegal} !== {st, done, ill}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d done=%b ill=%b expected state=%0d done=%b ill=%b",
               n, dbg_state, instr_done, illegal, st, done, ill);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // add
    add("add F",   R, 3'b000, 7'h00, 0, 1, e_fetch(1, 0));
    add("add D",   R, 3'b000, 7'h00, 0, 1, e_dec(2'b00));
    add("add X",   R, 3'b000, 7'h00, 0, 1, ex(S_XR, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h0, 0, 0));
    add("add WB",  R, 3'b000, 7'h00, 0, 1, e_wb());
    // sub
    add("sub F",   R, 3'b000, F7A, 0, 1, e_fetch(1, 1));
    add("sub D",   R, 3'b000, F7A, 0, 1, e_dec(2'b00));
    add("sub X",   R, 3'b000, F7A, 0, 1, ex(S_XR, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0, 0));
    add("sub WB",  R, 3'b000, F7A, 0, 1, e_wb());
    // sltu
    add("sltu F",  R, 3'b011, 7'h00, 0, 1, e_fetch(1, 1));
    add("sltu D",  R, 3'b011, 7'h00, 0, 1, e_dec(2'b00));
    add("sltu X",  R, 3'b011, 7'h00, 0, 1, ex(S_XR, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h9, 0, 0));
    add("sltu WB", R, 3'b011, 7'h00, 0, 1, e_wb());
    // lw with two wait cycles in MEMREAD
    add("lw F",    LW, 3'b010, 7'h00, 0, 1, e_fetch(1, 1));
    add("lw D",    LW, 3'b010, 7'h00, 0, 1, e_dec(2'b00));
    add("lw MA",   LW, 3'b010, 7'h00, 0, 1, ex(S_MA, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 0, 0));
    add("lw MR0",  LW, 3'b010, 7'h00, 0, 0, ex(S_MR, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    add("lw MR1",  LW, 3'b010, 7'h00, 0, 0, ex(S_MR, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    add("lw MR2",  LW, 3'b010, 7'h00, 0, 1, ex(S_MR, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    add("lw WB",   LW, 3'b010, 7'h00, 0, 1, ex(S_MW, 0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    // sw with a fetch wait, mem_ready ignored in DECODE/MEMADR, one write wait
    add("sw Fw",   SW, 3'b010, 7'h00, 0, 0, e_fetch(0, 1));
    add("sw F",    SW, 3'b010, 7'h00, 0, 1, e_fetch(1, 0));
    add("sw D",    SW, 3'b010, 7'h00, 0, 0, e_dec(2'b01));
    add("sw MA",   SW, 3'b010, 7'h00, 0, 0, ex(S_MA, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 4'h0, 0, 0));
    add("sw MWR0", SW, 3'b010, 7'h00, 0, 0, ex(S_MWR, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    add("sw MWR1", SW, 3'b010, 7'h00, 0, 1, ex(S_MWR, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    // beq / bne, both Zero values
    add("beq1 F",  BR, 3'b000, 7'h00, 1, 1, e_fetch(1, 1));
    add("beq1 D",  BR, 3'b000, 7'h00, 1, 1, e_dec(2'b10));
    add("beq1 B",  BR, 3'b000, 7'h00, 1, 1, ex(S_BR, 1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0, 0));
    add("beq0 F",  BR, 3'b000, 7'h00, 0, 1, e_fetch(1, 1));
    add("beq0 D",  BR, 3'b000, 7'h00, 0, 1, e_dec(2'b10));
    add("beq0 B",  BR, 3'b000, 7'h00, 0, 1, ex(S_BR, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0, 0));
    add("bne1 F",  BR, 3'b001, 7'h00, 1, 1, e_fetch(1, 1));
    add("bne1 D",  BR, 3'b001, 7'h00, 1, 1, e_dec(2'b10));
    add("bne1 B",  BR, 3'b001, 7'h00, 1, 1, ex(S_BR, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0, 0));
    add("bne0 F",  BR, 3'b001, 7'h00, 0, 1, e_fetch(1, 1));
    add("bne0 D",  BR, 3'b001, 7'h00, 0, 1, e_dec(2'b10));
    add("bne0 B",  BR, 3'b001, 7'h00, 0, 1, ex(S_BR, 1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0, 0));
    // srai
    add("srai F",  I, 3'b101, F7A, 0, 1, e_fetch(1, 1));
    add("srai D",  I, 3'b101, F7A, 0, 1, e_dec(2'b00));
    add("srai X",  I, 3'b101, F7A, 0, 1, ex(S_XI, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 4'h8, 0, 0));
    add("srai WB", I, 3'b101, F7A, 0, 1, e_wb());
    // addi with funct7[5] set still adds
    add("addi F",  I, 3'b000, F7A, 0, 1, e_fetch(1, 1));
    add("addi D",  I, 3'b000, F7A, 0, 1, e_dec(2'b00));
    add("addi X",  I, 3'b000, F7A, 0, 1, ex(S_XI, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 0, 0));
    add("addi WB", I, 3'b000, F7A, 0, 1, e_wb());
    // jal
    add("jal F",   JL, 3'b000, 7'h00, 0, 1, e_fetch(1, 1));
    add("jal D",   JL, 3'b000, 7'h00, 0, 1, e_dec(2'b11));
    add("jal J",   JL, 3'b000, 7'h00, 0, 1, ex(S_J, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 4'h0, 0, 0));
    add("jal WB",  JL, 3'b000, 7'h00, 0, 1, e_wb());
    add("jal F2",  BAD, 3'b000, 7'h00, 0, 1, e_fetch(1, 1));

    // Reset state
    rst_n = 1'b0;
    drive(R, 3'b000, 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("reset", e_fetch(0, 0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].rdy);
      #1 chk(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Illegal opcode: now in DECODE with BAD, then sticky TRAP
    drive(BAD, 3'b000, 7'h00, 1'b0, 1'b1);
    #1 chk("trap D", e_dec(2'b00));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(BAD, 3'b000, 7'h00, 1'b1, i[0]);
      #1 chk("trap hold", ex(S_T, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1));
      @(negedge clk);
    end

    // Reset clears TRAP and illegal
    drive(SW, 3'b010, 7'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("trap reset", e_fetch(0, 0));
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-MEMWRITE drops MemWrite immediately
    drive(SW, 3'b010, 7'h00, 1'b0, 1'b1);
    #1 chk("sw2 F", e_fetch(1, 0));
    @(negedge clk);
    drive(SW, 3'b010, 7'h00, 1'b0, 1'b0);
    #1 chk("sw2 D", e_dec(2'b01));
    @(negedge clk);
    #1 chk("sw2 MA", ex(S_MA, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 4'h0, 0, 0));
    @(negedge clk);
    #1 chk("sw2 MWR", ex(S_MWR, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
    #1 rst_n = 1'b0;
    #1 chk("rst in MEMWRITE", e_fetch(0, 0));
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Branch with unsupported funct3 traps without retiring
    drive(BR, 3'b010, 7'h00, 1'b1, 1'b1);
    #1 chk("bbad F", e_fetch(1, 0));
    @(negedge clk);
    #1 chk("bbad D", e_dec(2'b10));
    @(negedge clk);
    #1 chk_sdi("bbad B", S_BR, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_sdi("bbad T", S_T, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_sdi("bbad T2", S_T, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
